div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle 32-bit signed/unsigned divide sequencer for the EX stage of the five-stage pipeline. It accepts a divide request from EX and runs a restoring radix-2 divider, one quotient bit per cycle. It holds a 64-bit {remainder, quotient} result until EX releases the request. While the result is pending, EX raises its stall request, so the stall controller freezes PC, IF, ID and EX.

## Interface
- `WIDTH`, default 32: operand width; the iteration count equals WIDTH.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset is synchronous and active-high; sampled on `clk`.
- `signed_div_i` input 1: 1 means two's-complement divide, 0 means unsigned; sampled only on the start edge.
- `opdata1_i` input WIDTH: dividend; sampled only on the start edge.
- `opdata2_i` input WIDTH: divisor; sampled only on the start edge.
- `start_i` input 1: request from EX; must stay high until `ready_o` is seen.
- `annul_i` input 1: cancel from the flush path; overrides `start_i`.
- `result_o` output 2*WIDTH: registered result, {remainder, quotient}.
- `ready_o` output 1: registered; high only in state END.
- `busy_o` output 1: registered; high in states ON and BYZERO.

## Operation
- States:
  - IDLE (reset state).
  - BYZERO.
  - ON, with iteration counter `cnt` of log2(WIDTH)+1 bits.
  - END.
- IDLE:
  - If `start_i & ~annul_i` and divisor == 0, go to BYZERO.
  - If `start_i & ~annul_i` and divisor != 0, go to ON with `cnt` = 0.
  - On the ON transition, latch: the absolute values of the operands when signed and negative (raw values otherwise), `signed_div_i`, and the original operand sign bits.
  - Load the working register `dividend[2*WIDTH:0]` = {WIDTH'b0, |op1|, 1'b0}.
  - Otherwise stay in IDLE; outputs unchanged.
- ON, while `cnt` < WIDTH:
  - Compute `diff` = `dividend[2*WIDTH:WIDTH]` − {1'b0, |op2|}, (WIDTH+1)-bit arithmetic.
  - If `diff` is negative: `dividend` <= `dividend` << 1.
  - Else: `dividend` <= {`diff[WIDTH-1:0]`, `dividend[WIDTH-1:0]`, 1'b1}.
  - `cnt`++.
- ON, when `cnt` == WIDTH:
  - Quotient = `dividend[WIDTH-1:0]`; remainder = `dividend[2*WIDTH:WIDTH+1]`.
  - If signed: negate the quotient when the operand signs differ; negate the remainder when the dividend was negative.
  - Register `result_o` = {rem, quo}, set `ready_o` = 1, go to END.
- BYZERO: next edge sets `result_o` = 0, `ready_o` = 1, goes to END.
- END:
  - If `start_i` is low, go to IDLE and clear `ready_o` and `result_o` to 0.
  - If `start_i` is high, hold the result and `ready_o`.
- `annul_i` high in ON or BYZERO: next edge returns to IDLE. `result_o` stays 0, `ready_o` stays 0, and `cnt` is cleared.
- Operand changes after the start edge have no effect.
- Signed overflow (0x80000000 / −1) wraps: quotient 0x80000000, remainder 0. No exception is raised.

## Timing
- Reset values: state IDLE, `result_o` 0, `ready_o` 0, `busy_o` 0, `cnt` 0.
- `rst` mid-operation aborts on that edge to IDLE with all reset values; no partial result is visible.
- Non-zero divisor: `start_i` first high in cycle 0 gives `busy_o` high in cycles 1..WIDTH+1 and `ready_o` high from cycle WIDTH+2. For WIDTH=32 that is cycle 34.
- Zero divisor: `busy_o` high in cycle 1; `ready_o` high from cycle 2.
- `ready_o` stays high until the first cycle after `start_i` falls. A new start is accepted from IDLE only, so at most one cycle after release.
- `annul_i` and `start_i` both high in IDLE: no start.
- `annul_i` in END: ignored; END exits only on `start_i` low.

## Structure
- Constants belong in the shared defines include:
  - state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd`;
  - `DivResultReady` / `DivResultNotReady`;
  - `DivStart` / `DivStop`;
  - `RstEnable`.
- One combinational sub-module, `div_step`, is natural: the (WIDTH+1)-bit trial subtract and the shift/merge of one iteration. The FSM, counter, sign fix-up and output registers stay in `div_seq`.

## Test plan
- Unsigned divide: 100 / 7, `signed_div_i`=0 → `ready_o` in cycle 34, `result_o` = {32'd2, 32'd14}; `busy_o` high in cycles 1..33 only.
- Signed, negative operands:
  - −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- Divide by zero: 5 / 0 → `ready_o` in cycle 2, `result_o` = 0; hold `start_i` 5 more cycles and `ready_o` and the result stay stable; drop `start_i` and the next cycle shows `ready_o` = 0.
- Annul: raise `annul_i` in cycle 10 of an ON run → IDLE on the next edge, `ready_o` never asserted; a following start of 9/3 completes in 34 cycles with {0, 3}.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → {32'd0, 32'h80000000}. Unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Reset mid-run: assert `rst` in cycle 20 → next cycle all outputs 0 and state IDLE; a start immediately after reset completes normally.

Source files
------------

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared constants for the multi-cycle divide sequencer.
//   div_state_e        : FSM state encodings (DivFree, DivByZero, DivOn, DivEnd)
//   DivResultReady     : ready_o level when a result is held
//   DivResultNotReady  : ready_o level when no result is held
//   DivStart / DivStop : start_i levels
//   RstEnable          : active level of rst
package div_seq_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic RstEnable         = 1'b1;

endpackage

// File: rtl/div_seq_step.sv
// div_step: one iteration of the restoring radix-2 divider (combinational).
//   dividend      in  [2*WIDTH:0] : working register {partial remainder, dividend/quotient bits, pad}
//   divisor       in  [WIDTH-1:0] : magnitude of the divisor
//   dividend_next out [2*WIDTH:0] : working register after this iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [2*WIDTH:0] dividend_next
);

    logic [WIDTH:0] diff;

    // Trial subtract in WIDTH+1 bits; the top bit is the borrow.
    assign diff = dividend[2*WIDTH:WIDTH] - {1'b0, divisor};

    // Borrow: restore (plain shift, new quotient bit 0).
    // No borrow: keep the difference and shift in a quotient bit of 1.
    assign dividend_next = diff[WIDTH]
        ? {dividend[2*WIDTH-1:0], 1'b0}
        : {diff[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle signed/unsigned divide sequencer for the EX stage.
// One quotient bit per cycle; the {remainder, quotient} result is held
// until the requester drops start_i.
//   clk, rst      : clock, synchronous active-high reset
//   signed_div_i  : 1 = two's-complement divide (sampled on the start edge)
//   opdata1_i     : dividend (sampled on the start edge)
//   opdata2_i     : divisor  (sampled on the start edge)
//   start_i       : request, held high until ready_o is seen
//   annul_i       : cancel; overrides start_i, aborts ON/BYZERO
//   result_o      : registered {remainder, quotient}
//   ready_o       : registered, high only in END
//   busy_o        : registered, high in ON and BYZERO
//   state_dbg     : current FSM state, for observation only
//
// Handshake: start_i is a level request. The divider accepts it only in
// IDLE (and only with annul_i low), raises ready_o once the result is held,
// and keeps result_o/ready_o stable until start_i is seen low, at which
// point it clears both and returns to IDLE on the same edge.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic [1:0]         state_dbg
);

    localparam int CntW = $clog2(WIDTH) + 1;

    div_state_e       state;
    div_state_e       state_next;
    logic [CntW-1:0]  cnt;
    logic             cnt_done;
    logic [2*WIDTH:0] dividend;
    logic [2*WIDTH:0] dividend_step;
    logic [WIDTH-1:0] divisor_abs;
    logic             sign_mode;
    logic             op1_neg;
    logic             op2_neg;
    logic             start_req;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;
    logic [WIDTH-1:0] quo_raw;
    logic [WIDTH-1:0] rem_raw;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign state_dbg = state;
    assign start_req = (start_i == DivStart) && !annul_i;
    assign cnt_done  = (cnt == CntW'(WIDTH));

    // Magnitudes are only taken in signed mode; the most negative value
    // maps onto itself, which is the correct unsigned magnitude.
    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    assign quo_raw = dividend[WIDTH-1:0];
    assign rem_raw = dividend[2*WIDTH:WIDTH+1];

    // Quotient sign follows the operand sign difference; the remainder
    // takes the sign of the dividend (truncating division).
    assign quo_fix = (sign_mode && (op1_neg ^ op2_neg)) ? (~quo_raw + 1'b1) : quo_raw;
    assign rem_fix = (sign_mode && op1_neg) ? (~rem_raw + 1'b1) : rem_raw;

    div_step #(.WIDTH(WIDTH)) u_step (
        .dividend      (dividend),
        .divisor       (divisor_abs),
        .dividend_next (dividend_step)
    );

    always_comb begin
        state_next = state;
        case (state)
            DivFree: begin
                if (start_req) begin
                    state_next = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                state_next = annul_i ? DivFree : DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else if (cnt_done) begin
                    state_next = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_next = DivFree;
                end
            end
            default: state_next = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state       <= DivFree;
            cnt         <= '0;
            dividend    <= '0;
            divisor_abs <= '0;
            sign_mode   <= 1'b0;
            op1_neg     <= 1'b0;
            op2_neg     <= 1'b0;
            result_o    <= '0;
            ready_o     <= DivResultNotReady;
            busy_o      <= 1'b0;
        end else begin
            state  <= state_next;
            busy_o <= (state_next == DivOn) || (state_next == DivByZero);
            case (state)
                DivFree: begin
                    if (start_req && (opdata2_i != '0)) begin
                        cnt         <= '0;
                        dividend    <= {{WIDTH{1'b0}}, op1_abs, 1'b0};
                        divisor_abs <= op2_abs;
                        sign_mode   <= signed_div_i;
                        op1_neg     <= opdata1_i[WIDTH-1];
                        op2_neg     <= opdata2_i[WIDTH-1];
                    end
                end
                DivByZero: begin
                    if (!annul_i) begin
                        result_o <= '0;
                        ready_o  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        cnt <= '0;
                    end else if (!cnt_done) begin
                        dividend <= dividend_step;
                        cnt      <= cnt + CntW'(1);
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= DivResultReady;
                        cnt      <= '0;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;
  import div_seq_pkg::*;

  localparam int WIDTH = 32;

  logic              clk;
  logic              rst;
  logic              signed_div;
  logic [WIDTH-1:0]  op1;
  logic [WIDTH-1:0]  op2;
  logic              start;
  logic              annul;
  logic [2*WIDTH-1:0] result;
  logic              ready;
  logic              busy;
  logic [1:0]        state_dbg;

  logic [2*WIDTH-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  div_seq #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: truncating division on 64-bit integers, low halves kept.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic ready_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
    ready_prev = ready;
  end

  // ---------------- driver ----------------
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int cyc, busy_cnt, first_busy, ready_cyc, exp_lat, exp_busy;
    exp = model(sgn, a, b);
    exp_q.push_back(exp);
    exp_lat  = (b == 0) ? 2 : WIDTH + 2;
    exp_busy = (b == 0) ? 1 : WIDTH + 1;
    @(negedge clk);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
    cyc = 0; busy_cnt = 0; first_busy = -1; ready_cyc = -1;
    while (ready_cyc < 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      // Operands are scrambled after the start edge; they must not matter.
      if (cyc == 1) begin
        op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom_range(0, 1));
      end
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (ready) ready_cyc = cyc;
    end
    check("ready_latency", 64'(ready_cyc), 64'(exp_lat));
    if (ready_cyc < 0) begin
      start = 1'b0;
      return;
    end
    check("busy_first_cycle", 64'(first_busy), 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ready", 64'(ready), 64'd1);
      check("hold_result", result, exp);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("release_ready", 64'(ready), 64'd0);
    check("release_result", result, 64'd0);
  endtask

  // Start a run that will be aborted at cycle abort_cyc (no result expected).
  task automatic start_and_wait(input int abort_cyc);
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    for (int c = 0; c < abort_cyc; c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 64'(state_dbg), 64'(DivFree));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(ready), 64'd0);
    check({tag, "_result"}, result, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, -32'sd7, 32'd2, 0);
    run_div(1'b1, 32'd7, -32'sd2, 0);
    run_div(1'b0, 32'd5, 32'd0, 5);

    // Annul in the middle of an ON run.
    start_and_wait(10);
    annul = 1'b1;
    @(posedge clk); #1;
    check_idle("annul");
    annul = 1'b0; start = 1'b0;
    run_div(1'b0, 32'd9, 32'd3, 0);

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);

    // start and annul together in IDLE: no start.
    @(negedge clk);
    op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    check_idle("annul_idle");
    start = 1'b0; annul = 1'b0;

    // Reset in the middle of a run.
    start_and_wait(20);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("rst_mid");
    rst = 1'b0; start = 1'b0;
    run_div(1'b0, 32'd1000, 32'd33, 1);

    // Randomized operands.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
